// File: rtl/bus_mem_slave_pkg.sv
// Shared definitions for the bus memory slave: FSM encodings and wait counter width.
// Master-side bus task libraries import this package too, so they see the same encodings.
package bus_mem_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/bus_mem_slave_if.sv
// ce/rd/wr bus between a master and the memory slave.
interface bus_mem_slave_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              ce;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] data_rd;
  logic              ready;
  logic              err;

  modport master (
    output ce, rd, wr, addr, data_wr,
    input  data_rd, ready, err
  );

  modport slave (
    input  ce, rd, wr, addr, data_wr,
    output data_rd, ready, err
  );
endinterface

// File: rtl/bus_mem_array.sv
// Word storage for the bus slave: synchronous write, asynchronous read.
// Out-of-range addresses read as zero and never write.
module bus_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic w_in_range;
  logic r_in_range;

  assign w_in_range = (32'(waddr) < DEPTH);
  assign r_in_range = (32'(raddr) < DEPTH);

  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = r_in_range ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/bus_mem_slave.sv
// ce/rd/wr bus memory slave with configurable wait states, one-cycle ready pulse
// and error signalling for conflicting strobes or out-of-range addresses.
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  bus_mem_slave_if.slave bus
);
  localparam logic [WAIT_CNT_W-1:0] WS_L = WAIT_CNT_W'(WAIT_STATES);

  state_t state;
  state_t state_nxt;

  logic [WAIT_CNT_W-1:0] cnt;
  logic [WAIT_CNT_W-1:0] cnt_inc;
  logic                  capture;

  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_wr_q;

  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] data_rd_q;

  logic              rd_s;
  logic              wr_s;
  logic [ADDR_W-1:0] addr_s;
  logic              err_s;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  function automatic logic req_err(input logic r, input logic w, input logic [ADDR_W-1:0] a);
    return (r & w) | (32'(a) >= DEPTH);
  endfunction

  // With zero wait states IDLE goes straight to ACK, so the access being decided
  // this cycle comes from the live bus in IDLE and from the holding regs otherwise.
  assign rd_s    = (state == ST_IDLE) ? bus.rd   : rd_q;
  assign wr_s    = (state == ST_IDLE) ? bus.wr   : wr_q;
  assign addr_s  = (state == ST_IDLE) ? bus.addr : addr_q;
  assign err_s   = req_err(rd_s, wr_s, addr_s);
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ce && (bus.rd || bus.wr)) begin
          capture   = 1'b1;
          state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (cnt_inc == WS_L) state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      data_rd_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state == ST_WAIT) ? cnt_inc : '0;
      ready_q   <= (state_nxt == ST_ACK);
      err_q     <= (state_nxt == ST_ACK) && err_s;
      data_rd_q <= ((state_nxt == ST_ACK) && rd_s && !err_s) ? mem_rdata : '0;
    end
  end

  // Holding registers, loaded only when IDLE accepts a request
  always_ff @(posedge clk) begin
    if (capture) begin
      rd_q      <= bus.rd;
      wr_q      <= bus.wr;
      addr_q    <= bus.addr;
      data_wr_q <= bus.data_wr;
    end
  end

  // Commit on the edge leaving ACK; err_q is valid for the whole ACK cycle.
  assign mem_we = (state == ST_ACK) && wr_q && !err_q && !reset;

  bus_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (data_wr_q),
    .raddr (addr_s),
    .rdata (mem_rdata)
  );

  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.data_rd = data_rd_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: three instances covering zero wait states,
// three wait states, and a shallow 16-word memory.
module tb_bus_mem_slave;

  logic clk;
  logic rst;

  logic       ce_v   [3];
  logic       rd_v   [3];
  logic       wr_v   [3];
  logic [7:0] addr_v [3];
  logic [7:0] wd_v   [3];
  logic [7:0] rdd_v  [3];
  logic       rdy_v  [3];
  logic       err_v  [3];

  bus_mem_slave_if #(.DATA_W(8), .ADDR_W(8)) bif [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bif[g].ce      = ce_v[g];
    assign bif[g].rd      = rd_v[g];
    assign bif[g].wr      = wr_v[g];
    assign bif[g].addr    = addr_v[g];
    assign bif[g].data_wr = wd_v[g];
    assign rdd_v[g]       = bif[g].data_rd;
    assign rdy_v[g]       = bif[g].ready;
    assign err_v[g]       = bif[g].err;
  end

  bus_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk (clk), .reset (rst), .bus (bif[0]));
  bus_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk (clk), .reset (rst), .bus (bif[1]));
  bus_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(16),  .WAIT_STATES(1)) u_d16 (
    .clk (clk), .reset (rst), .bus (bif[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic [7:0] lat;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] mdl [3][256];
  int         n_chk  = 0;
  int         n_pass = 0;

  function automatic int ws_of(input int idx);
    return (idx == 0) ? 0 : (idx == 1) ? 3 : 1;
  endfunction

  function automatic int depth_of(input int idx);
    return (idx == 2) ? 16 : 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One bus access. 'chained' means ce was left high by the previous access, so
  // the slave re-samples after ACK->IDLE and the pulse lands one cycle later.
  task automatic access(input int idx, input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d,
                        input bit scramble, input bit hold, input bit chained);
    exp_t e;
    int   n;
    bit   seen;
    e.err  = (r & w) | (int'(a) >= depth_of(idx));
    e.data = (r && !e.err) ? mdl[idx][a] : 8'h00;
    e.lat  = 8'(chained ? ws_of(idx) + 3 : ws_of(idx) + 2);
    exp_q.push_back(e);
    if (w && !e.err) mdl[idx][a] = d;

    if (!chained) @(negedge clk);
    ce_v[idx] = 1'b1; rd_v[idx] = r; wr_v[idx] = w; addr_v[idx] = a; wd_v[idx] = d;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy_v[idx]) seen = 1'b1;
      else if (scramble) begin
        addr_v[idx] = 8'($urandom);
        wd_v[idx]   = 8'($urandom);
        wr_v[idx]   = 1'($urandom);
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check($sformatf("timeout[%0d]@%02h", idx, a), 32'(n), 32'(e.lat));
    end else begin
      check($sformatf("latency[%0d]@%02h", idx, a), 32'(n),           32'(e.lat));
      check($sformatf("err[%0d]@%02h", idx, a),     32'(err_v[idx]),  32'(e.err));
      check($sformatf("data_rd[%0d]@%02h", idx, a), 32'(rdd_v[idx]),  32'(e.data));
    end
    if (!hold) begin
      ce_v[idx] = 1'b0; rd_v[idx] = 1'b0; wr_v[idx] = 1'b0;
      @(negedge clk);
      check($sformatf("post_ready[%0d]", idx), 32'({rdy_v[idx], err_v[idx], rdd_v[idx]}), 32'h0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         saw;
    logic [7:0] ra;
    logic [7:0] rdat;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce_v[i] = 1'b0; rd_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = 8'h00; wd_v[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_out[%0d]", i), 32'({rdy_v[i], err_v[i], rdd_v[i]}), 32'h0);
    rst = 1'b0;

    // Zero wait states: write then read back
    access(0, 1'b0, 1'b1, 8'h11, 8'hAA, 1'b0, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);

    // Three wait states, bus scrambled while waiting
    access(1, 1'b0, 1'b1, 8'h12, 8'hAB, 1'b1, 1'b0, 1'b0);
    access(1, 1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 1'b0);

    // rd and wr both high
    access(0, 1'b0, 1'b1, 8'h13, 8'h0A, 1'b0, 1'b0, 1'b0);
    access(0, 1'b1, 1'b1, 8'h13, 8'hFF, 1'b0, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 1'b0, 1'b0);

    // 16-word instance: range boundary and out-of-range accesses
    access(2, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
    access(2, 1'b0, 1'b1, 8'h0F, 8'h3C, 1'b0, 1'b0, 1'b0);
    access(2, 1'b0, 1'b1, 8'h20, 8'h55, 1'b0, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT aborts the write
    access(1, 1'b0, 1'b1, 8'h14, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ce_v[1] = 1'b1; rd_v[1] = 1'b0; wr_v[1] = 1'b1; addr_v[1] = 8'h14; wd_v[1] = 8'hCC;
    @(negedge clk);
    rst = 1'b1;
    ce_v[1] = 1'b0; wr_v[1] = 1'b0;
    @(negedge clk);
    check("reset_in_wait", 32'({rdy_v[1], err_v[1], rdd_v[1]}), 32'h0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdy_v[1]) saw = 1'b1;
    end
    check("no_ready_after_abort", 32'(saw), 32'h0);
    access(1, 1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 1'b0, 1'b0);

    // ce held high: the same write is taken twice back to back
    access(1, 1'b0, 1'b1, 8'h15, 8'h01, 1'b0, 1'b1, 1'b0);
    access(1, 1'b0, 1'b1, 8'h15, 8'h01, 1'b0, 1'b0, 1'b1);
    access(1, 1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 1'b0, 1'b0);

    // Random write/read pairs on both deep instances
    for (int k = 0; k < 6; k++) begin
      ra   = 8'($urandom_range(8'h30, 8'hFF));
      rdat = 8'($urandom);
      access(k % 2, 1'b0, 1'b1, ra, rdat, 1'b0, 1'b0, 1'b0);
      access(k % 2, 1'b1, 1'b0, ra, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
